// File: rtl/fp_pkg.sv
// Shared helpers for the small-float formats: operand classes, result kinds,
// flag bit positions and the bias/max-exponent derivations.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2
  } cls_e;

  // Outcome of a multiply once both operand classes are known.
  typedef enum logic [1:0] {
    K_NUM  = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_e;

  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic cls_e fp_classify(input int e, input int emax);
    if (e == 0) return ZERO;
    if (e == emax) return INF;
    return NORM;
  endfunction

endpackage

// File: rtl/float_mult_pipe_if.sv
// Operand/result streams of the pipelined float multiplier.
interface float_mult_pipe_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
);
  localparam int W = 1 + EXP_W + MAN_W;

  // A beat moves only in a cycle where valid and ready are both high; the
  // producer holds valid and data steady until that cycle.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [2:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a mantissa given guard and sticky; carry means the
// mantissa wrapped to zero and the exponent must be bumped.
module fp_round_rne #(
  parameter int MAN_W = 8
) (
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  input  logic             sticky,
  output logic [MAN_W-1:0] man_out,
  output logic             carry
);
  logic up;

  assign up = guard & (sticky | man[0]);
  assign {carry, man_out} = {1'b0, man} + (MAN_W + 1)'(up);
endmodule

// File: rtl/float_mult_pipe.sv
// Three-stage float multiplier: S1 classify/multiply, S2 normalise/round,
// S3 range-check/pack into the output register.
module float_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  float_mult_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = fp_bias(EXP_W);
  localparam int EMAX = fp_emax(EXP_W);
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int XW   = EXP_W + 2;

  localparam logic signed [XW-1:0] EMAX_X   = XW'(EMAX);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [MAN_W-1:0]     NAN_MAN  = {1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: unpack, classify, multiply
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  cls_e             ca, cb;
  kind_e            kind1;
  logic [PW-1:0]    prod1;
  logic signed [XW-1:0] exp1;

  assign {sa, ea, ma} = bus.a;
  assign {sb, eb, mb} = bus.b;
  assign ca    = fp_classify(32'(ea), EMAX);
  assign cb    = fp_classify(32'(eb), EMAX);
  assign prod1 = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign exp1  = $signed(XW'(ea)) + $signed(XW'(eb)) - EXP_ZERO - XW'(BIAS);

  always_comb begin
    kind1 = K_NUM;
    if ((ca == ZERO && cb == INF) || (ca == INF && cb == ZERO)) kind1 = K_NAN;
    else if (ca == INF || cb == INF)                           kind1 = K_INF;
    else if (ca == ZERO || cb == ZERO)                         kind1 = K_ZERO;
  end

  logic                 s1_valid;
  kind_e                s1_kind;
  logic                 s1_sign;
  logic [PW-1:0]        s1_prod;
  logic signed [XW-1:0] s1_exp;

  // ---------------- S2: normalise and round
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     man_r;
  logic                 carry;
  logic [XW-1:0]        inc2;
  logic signed [XW-1:0] exp2;

  // Product lies in [1,4); dropping the leading one leaves mantissa, guard, sticky.
  assign norm = s1_prod[PW-1] ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .man     (norm[PW-2 -: MAN_W]),
    .guard   (norm[PW-2-MAN_W]),
    .sticky  (|norm[PW-3-MAN_W:0]),
    .man_out (man_r),
    .carry   (carry)
  );

  assign inc2 = XW'(s1_prod[PW-1]) + XW'(carry);
  assign exp2 = s1_exp + $signed(inc2);

  logic                 s2_valid;
  kind_e                s2_kind;
  logic                 s2_sign;
  logic [MAN_W-1:0]     s2_man;
  logic signed [XW-1:0] s2_exp;

  // ---------------- S3: range check and pack
  logic [W-1:0] res3;
  logic [2:0]   flg3;

  always_comb begin
    res3 = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
    flg3 = '0;
    case (s2_kind)
      K_ZERO: res3 = {s2_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      K_INF:  res3 = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_NAN: begin
        res3           = {1'b0, {EXP_W{1'b1}}, NAN_MAN};
        flg3[FLAG_INV] = 1'b1;
      end
      default: begin
        if (s2_exp >= EMAX_X) begin
          res3           = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg3[FLAG_OVF] = 1'b1;
        end else if (s2_exp <= EXP_ZERO) begin
          res3           = {s2_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          flg3[FLAG_UNF] = 1'b1;
        end
      end
    endcase
  end

  // ---------------- control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= '0;
    end else if (adv) begin
      s1_valid      <= bus.in_valid;
      s2_valid      <= s1_valid;
      bus.out_valid <= s2_valid;
      bus.result    <= res3;
      bus.flags     <= flg3;
    end
  end

  // Datapath stage registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_kind <= kind1;
      s1_sign <= sa ^ sb;
      s1_prod <= prod1;
      s1_exp  <= exp1;
      s2_kind <= s1_kind;
      s2_sign <= s1_sign;
      s2_man  <= man_r;
      s2_exp  <= exp2;
    end
  end
endmodule

// File: tb/tb_float_mult_pipe.sv
// Scoreboard bench for float_mult_pipe at the default 4/8 format.
module tb_float_mult_pipe;
  localparam int EXP_W = 4;
  localparam int MAN_W = 8;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NV    = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   accept_cyc;
  logic [W+2:0] exp_q[$];

  float_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  float_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor: every beat with out_valid is checked
  // against the head of the queue, including beats held under backpressure.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'(bus.result), 32'hFFFF_FFFF);
      end else begin
        check_eq("out", 32'({bus.flags, bus.result}), 32'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W+2:0] e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
    else begin
      exp_q.push_back(e);
      accept_cyc = cyc;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus table: {flags, result} expectations
  logic [W-1:0] va [NV];
  logic [W-1:0] vb [NV];
  logic [W+2:0] ve [NV];

  initial begin
    va[0] = 13'h0780; vb[0] = 13'h0780; ve[0] = {3'b000, 13'h0820};
    va[1] = 13'h1800; vb[1] = 13'h0780; ve[1] = {3'b000, 13'h1880};
    va[2] = 13'h0701; vb[2] = 13'h0780; ve[2] = {3'b000, 13'h0782};
    va[3] = 13'h0701; vb[3] = 13'h0701; ve[3] = {3'b000, 13'h0702};
    va[4] = 13'h0EFF; vb[4] = 13'h0EFF; ve[4] = {3'b010, 13'h0F00};
    va[5] = 13'h0100; vb[5] = 13'h0100; ve[5] = {3'b001, 13'h0000};
    va[6] = 13'h0000; vb[6] = 13'h0F00; ve[6] = {3'b100, 13'h0F80};
    va[7] = 13'h1000; vb[7] = 13'h0700; ve[7] = {3'b000, 13'h1000};
  end

  // ---------------- test sequence
  initial begin
    int n;
    int first_acc;
    int idx;
    logic saw_stall_low;
    logic saw_stale;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rst_result",    32'(bus.result),    32'd0);
    check_eq("rst_flags",     32'(bus.flags),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operation: latency from accept to out_valid.
    send(va[0], vb[0], ve[0]);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(cyc - accept_cyc), 32'd3);
    drain("drain_single");

    // Back-to-back stream of all vectors: one accept per cycle.
    @(posedge clk);
    #1;
    first_acc = -1;
    for (int i = 0; i < NV; i++) begin
      send(va[i], vb[i], ve[i]);
      if (i == 0) first_acc = accept_cyc;
    end
    check_eq("throughput", 32'(accept_cyc - first_acc), 32'(NV - 1));
    drain("drain_stream");

    // Stall: consumer refuses results for cycles 4..8 of a 5-pair stream.
    @(posedge clk);
    #1;
    saw_stall_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          idx = (i * 3 + 1) % NV;
          send(va[idx], vb[idx], ve[idx]);
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          bus.out_ready = !(k >= 4 && k <= 8);
          @(negedge clk);
          if (k >= 4 && k <= 8 && !bus.in_ready) saw_stall_low = 1'b1;
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    check_eq("stall_in_ready_low", 32'(saw_stall_low), 32'd1);
    drain("drain_stall");

    // Reset with two operations in flight.
    @(posedge clk);
    #1;
    send(va[2], vb[2], ve[2]);
    send(va[4], vb[4], ve[4]);
    @(posedge clk);
    #2;
    check_eq("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("mid_rst_result",    32'(bus.result),    32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_stale = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) saw_stale = 1'b1;
    end
    check_eq("no_stale_after_reset", 32'(saw_stale), 32'd0);

    // Pipeline still works after the reset.
    @(posedge clk);
    #1;
    send(va[6], vb[6], ve[6]);
    send(va[3], vb[3], ve[3]);
    drain("drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
